// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip memory stream master.
package onchip_mem_pkg;

  localparam int         DATA_W            = 32;
  localparam int         MEM_WORDS_DEFAULT = 40000;
  localparam logic [3:0] BE_ALL            = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DRAIN,
    S_WR,
    S_DONE
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of 2.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // which entries are live, so stale words are never observable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/onchip_mem_stream_master.sv
// Avalon-MM master moving word blocks between on-chip RAM and Avalon-ST
// source/sink ports, with credit-limited read issue into a return FIFO.
module onchip_mem_stream_master
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int MEM_WORDS    = MEM_WORDS_DEFAULT,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e                  r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic [CNT_W-1:0]        r_remaining;
  logic                    r_busy;
  logic                    r_done;
  logic [CW-1:0]           r_inflight;
  logic [READ_LATENCY-1:0] r_vpipe;

  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_head;
  logic              w_credit;
  logic              w_rd_req;
  logic              w_rd_acc;
  logic              w_ret;
  logic              w_pop;
  logic              w_wr_mode;
  logic              w_wr_beat;

  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_WORDS - 1)) ? '0 : a + 1'b1;
  endfunction

  // Words already buffered or still in flight may never exceed the FIFO depth.
  assign w_credit  = ({1'b0, w_fifo_count} + {1'b0, r_inflight}) < (CW + 1)'(FIFO_DEPTH);
  assign w_rd_req  = (r_state == S_RD_ISSUE) && w_credit;
  assign w_rd_acc  = w_rd_req && !avm_waitrequest;
  assign w_ret     = r_vpipe[READ_LATENCY-1];
  assign w_pop     = !w_fifo_empty && src_ready;
  assign w_wr_mode = (r_state == S_WR);
  assign w_wr_beat = w_wr_mode && snk_valid && !avm_waitrequest;

  stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_ret),
    .i_data  (avm_readdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vpipe    <= '0;
      r_inflight <= '0;
    end else begin
      r_vpipe <= (r_vpipe << 1) | READ_LATENCY'(w_rd_acc);
      case ({w_rd_acc, w_ret})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= start_addr;
            r_remaining <= word_count;
            r_busy      <= 1'b1;
            if (word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= dir ? S_WR : S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          if (w_rd_acc) begin
            r_addr      <= f_next_addr(r_addr);
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CNT_W'(1)) r_state <= S_RD_DRAIN;
          end
        end
        S_RD_DRAIN: begin
          if (r_inflight == '0 && w_fifo_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_WR: begin
          if (w_wr_beat) begin
            r_addr      <= f_next_addr(r_addr);
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_address    = r_addr;
  assign avm_read       = w_rd_req;
  assign avm_write      = w_wr_mode && snk_valid;
  assign avm_chipselect = w_rd_req || (w_wr_mode && snk_valid);
  assign avm_byteenable = BE_ALL;
  assign avm_writedata  = w_wr_mode ? snk_data : '0;
  assign snk_ready      = w_wr_mode && !avm_waitrequest;
  assign src_valid      = !w_fifo_empty;
  assign src_data       = w_fifo_empty ? '0 : w_fifo_head;

endmodule

// File: tb/tb_onchip_mem_stream_master.sv
// Self-checking bench: RAM slave, stream drivers and a transfer-level model.
module tb_onchip_mem_stream_master;

  localparam int MEM_WORDS = 40000;
  localparam int DEPTH     = 4;
  localparam int LAT       = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done;
  logic [15:0] avm_address;
  logic        avm_chipselect, avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready = 1'b0;
  logic [31:0] snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;

  onchip_mem_stream_master #(
    .ADDR_W(16), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM slave with fixed one-cycle read latency; stale cycles return noise.
  logic [31:0] mem [0:MEM_WORDS-1];
  always @(posedge clk) begin
    if (avm_chipselect && avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address];
    else avm_readdata <= $urandom;
    if (avm_chipselect && avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
  end

  // Fabric / stream-side drivers
  bit          wait_rand = 0, ready_rand = 0, snk_rand = 0, ready_force = 1;
  int          beat_idx = 0, stall_at = -1, stall_left = 0;
  logic [31:0] wr_q[$];
  always @(posedge clk) begin
    if (snk_valid && snk_ready && !reset) begin
      void'(wr_q.pop_front());
      beat_idx++;
    end
    #1;
    avm_waitrequest = wait_rand && ($urandom_range(0, 3) == 0);
    if (stall_left > 0 && beat_idx == stall_at && busy) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end
    src_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_force;
    if (wr_q.size() > 0 && (!snk_rand || $urandom_range(0, 3) != 0)) begin
      snk_valid = 1'b1;
      snk_data  = wr_q[0];
    end else begin
      snk_valid = 1'b0;
      snk_data  = $urandom;
    end
  end

  // Transfer-level model: phase 0 idle, 1 moving words, 3 read tail, 2 done pulse
  int          cyc = 0;
  bit          mon_en = 0;
  int          ph = 0;
  bit          m_dir = 0;
  int          m_addr = 0, left_issue = 0, left_del = 0, issued = 0, popped = 0;
  int          acc_edge[$];
  logic [31:0] expq[$];
  logic [31:0] pop_log[$];
  int          addr_log[$];
  int          done_cnt = 0, wr_stall_seen = 0, max_out = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      int  avail;
      bit  exp_rd, exp_wr;
      avail = 0;
      foreach (acc_edge[i]) if (acc_edge[i] + LAT <= cyc) avail++;
      exp_rd = (ph == 1) && !m_dir && left_issue > 0 && (issued - popped) < DEPTH;
      exp_wr = (ph == 1) && m_dir && snk_valid;
      check("byteenable", 64'(avm_byteenable), 64'hF);
      check("busy", 64'(busy), 64'(ph != 0));
      check("done", 64'(done), 64'(ph == 2));
      check("src_valid", 64'(src_valid), 64'(avail > 0));
      if (src_valid && avail > 0) check("src_data", 64'(src_data), 64'(expq[0]));
      check("avm_read", 64'(avm_read), 64'(exp_rd));
      check("avm_write", 64'(avm_write), 64'(exp_wr));
      check("chipselect", 64'(avm_chipselect), 64'(exp_rd || exp_wr));
      check("snk_ready", 64'(snk_ready), 64'((ph == 1) && m_dir && !avm_waitrequest));
      if (exp_wr) check("writedata", 64'(avm_writedata), 64'(snk_data));
      if (exp_rd || exp_wr) check("avm_address", 64'(avm_address), 64'(m_addr));
      if (done) done_cnt++;
      if (reset) begin
        ph = 0; issued = 0; popped = 0;
        acc_edge.delete(); expq.delete();
      end else if (ph == 2) begin
        ph = 0;
      end else if (ph == 3) begin
        ph = 2;
      end else if (ph == 0) begin
        if (start) begin
          m_dir = dir; m_addr = int'(start_addr);
          left_issue = int'(word_count); left_del = int'(word_count);
          issued = 0; popped = 0;
          ph = (word_count == 0) ? 2 : 1;
        end
      end else if (!m_dir) begin
        if (avm_chipselect && avm_read && !avm_waitrequest) begin
          addr_log.push_back(int'(avm_address));
          expq.push_back(mem[m_addr]);
          acc_edge.push_back(cyc + 1);
          issued++; left_issue--;
          m_addr = (m_addr + 1) % MEM_WORDS;
        end
        if (src_valid && src_ready && expq.size() > 0) begin
          pop_log.push_back(src_data);
          void'(expq.pop_front());
          void'(acc_edge.pop_front());
          popped++; left_del--;
          if (left_del == 0) ph = 3;
        end
        if (issued - popped > max_out) max_out = issued - popped;
      end else begin
        if (snk_valid && !snk_ready) wr_stall_seen++;
        if (snk_valid && snk_ready) begin
          addr_log.push_back(int'(avm_address));
          m_addr = (m_addr + 1) % MEM_WORDS;
          left_del--;
          if (left_del == 0) ph = 2;
        end
      end
    end
  end

  task automatic do_start(input bit d, input int a, input int c);
    @(posedge clk); #1;
    start = 1'b1; dir = d; start_addr = 16'(a); word_count = 16'(c);
    @(posedge clk); #1;
    start = 1'b0; start_addr = 16'($urandom); word_count = 16'($urandom);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_timeout"}, 64'(busy), 64'(0));
  endtask

  task automatic clear_logs();
    pop_log.delete(); addr_log.delete(); max_out = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'(i * 3);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_src_valid", 64'(src_valid), 0);
    check("rst_avm_read", 64'(avm_read), 0);
    check("rst_avm_address", 64'(avm_address), 0);
    check("rst_byteenable", 64'(avm_byteenable), 64'hF);
    check("rst_snk_ready", 64'(snk_ready), 0);
    mon_en = 1;

    // Read, no stall
    clear_logs(); d0 = done_cnt;
    do_start(0, 16'h0010, 4);
    wait_idle("rd_basic", 200);
    check("rd_basic_n", 64'(pop_log.size()), 4);
    if (pop_log.size() == 4) begin
      check("rd_basic_0", 64'(pop_log[0]), 64'h30);
      check("rd_basic_1", 64'(pop_log[1]), 64'h33);
      check("rd_basic_2", 64'(pop_log[2]), 64'h36);
      check("rd_basic_3", 64'(pop_log[3]), 64'h39);
    end
    check("rd_basic_done", 64'(done_cnt - d0), 1);

    // Read with backpressure
    clear_logs();
    ready_force = 0;
    do_start(0, 16'h0200, 8);
    repeat (20) @(posedge clk);
    #1;
    check("bp_issued", 64'(addr_log.size()), 64'(DEPTH));
    ready_force = 1;
    wait_idle("bp", 300);
    check("bp_n", 64'(pop_log.size()), 8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++)
      check("bp_data", 64'(pop_log[i]), 64'((16'h200 + i) * 3));
    check("bp_max_out", 64'(max_out), 64'(DEPTH));

    // Address wrap
    clear_logs();
    do_start(0, 39998, 4);
    wait_idle("wrap", 200);
    check("wrap_n", 64'(addr_log.size()), 4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", 64'(addr_log[0]), 39998);
      check("wrap_a1", 64'(addr_log[1]), 39999);
      check("wrap_a2", 64'(addr_log[2]), 0);
      check("wrap_a3", 64'(addr_log[3]), 1);
    end
    if (pop_log.size() == 4) check("wrap_d2", 64'(pop_log[2]), 0);

    // Zero count
    clear_logs(); d0 = done_cnt;
    do_start(0, 5, 0);
    wait_idle("zero", 20);
    check("zero_done", 64'(done_cnt - d0), 1);
    check("zero_access", 64'(addr_log.size()), 0);

    // Start while busy is ignored
    clear_logs(); d0 = done_cnt;
    ready_rand = 1;
    do_start(0, 16'h0300, 6);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; dir = 1'b1; start_addr = 16'h0050; word_count = 16'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("busy_start", 300);
    ready_rand = 0;
    check("busy_start_n", 64'(pop_log.size()), 6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++)
      check("busy_start_data", 64'(pop_log[i]), 64'((16'h300 + i) * 3));
    check("busy_start_done", 64'(done_cnt - d0), 1);

    // Reset during the third beat of a read
    begin
      int n = 0;
      clear_logs();
      do_start(0, 16'h0400, 8);
      while (pop_log.size() < 2 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("mid_reach", 64'(pop_log.size()), 2);
      d0 = done_cnt;
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("mid_busy", 64'(busy), 0);
      check("mid_done", 64'(done), 0);
      check("mid_src_valid", 64'(src_valid), 0);
      check("mid_src_data", 64'(src_data), 0);
      check("mid_cs", 64'(avm_chipselect), 0);
      check("mid_address", 64'(avm_address), 0);
      repeat (5) @(posedge clk);
      #1 check("mid_no_done", 64'(done_cnt - d0), 0);
      clear_logs();
      do_start(0, 16'h0010, 4);
      wait_idle("mid_restart", 200);
      check("mid_restart_n", 64'(pop_log.size()), 4);
      if (pop_log.size() == 4) check("mid_restart_d3", 64'(pop_log[3]), 64'h39);
    end

    // Write with a two-cycle stall on the second beat
    clear_logs(); d0 = done_cnt;
    wr_q = '{32'hA, 32'hB, 32'hC};
    beat_idx = 0; stall_at = 1; stall_left = 2; wr_stall_seen = 0;
    do_start(1, 16'h0100, 3);
    wait_idle("wr", 100);
    @(posedge clk); #1;
    check("wr_m0", 64'(mem[16'h100]), 64'hA);
    check("wr_m1", 64'(mem[16'h101]), 64'hB);
    check("wr_m2", 64'(mem[16'h102]), 64'hC);
    check("wr_stalls", 64'(wr_stall_seen), 2);
    check("wr_done", 64'(done_cnt - d0), 1);
    stall_at = -1;

    // Randomised transfers in both directions
    wait_rand = 1; ready_rand = 1; snk_rand = 1;
    for (int t = 0; t < 16; t++) begin
      bit          d;
      int          a, c;
      logic [31:0] wd[$];
      d = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? MEM_WORDS - 1 - $urandom_range(0, 5)
                                      : $urandom_range(0, MEM_WORDS - 1);
      c = $urandom_range(0, 12);
      clear_logs(); wd.delete(); d0 = done_cnt;
      if (d) begin
        for (int i = 0; i < c; i++) wd.push_back($urandom);
        wr_q = wd;
      end
      do_start(d, a, c);
      wait_idle("rnd", 2000);
      @(posedge clk); #1;
      check("rnd_done", 64'(done_cnt - d0), 1);
      if (d) begin
        for (int i = 0; i < c; i++)
          check("rnd_wr_mem", 64'(mem[(a + i) % MEM_WORDS]), 64'(wd[i]));
      end else begin
        check("rnd_rd_n", 64'(pop_log.size()), 64'(c));
        for (int i = 0; i < c && i < pop_log.size(); i++)
          check("rnd_rd_data", 64'(pop_log[i]), 64'(mem[(a + i) % MEM_WORDS]));
      end
    end
    wait_rand = 0; ready_rand = 0; snk_rand = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
